// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator-ALU command issuer: opcodes, FSM states,
// the captured-result record and an opcode legality helper.
package alu_pkg;

    localparam int ALU_N = 8;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_ADD  = 4'd7;
    localparam logic [3:0] OP_MULT = 4'd8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SLEEP = 2'd1,
        ST_OFF   = 2'd2,
        ST_WAKE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0]       op;
        logic             err;
        logic [ALU_N-1:0] data;
    } res_rec_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_MULT);
    endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Host-facing command and result handshakes of alu_cmd_issuer.
interface alu_cmd_issuer_if #(
    parameter int N = 8
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [N-1:0] cmd_data;
    logic         cmd_last;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_data;
    logic [3:0]   res_op;
    logic         res_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_last, res_ready,
        input  cmd_ready, res_valid, res_data, res_op, res_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_last, res_ready,
        output cmd_ready, res_valid, res_data, res_op, res_err
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count output.
// DEPTH must be a power of two; pushes when full and pops when empty are ignored.
module alu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en_s, pop_en_s;

    assign push_en_s = push && (count_q != CW'(DEPTH));
    assign pop_en_s  = pop && (count_q != CW'(0));
    assign pop_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Next storage, pointer and occupancy values
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_en_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CW'(push_en_s) - CW'(pop_en_s);
    end

    // FIFO state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Command front end for the accumulator ALU: command FIFO, one-per-cycle issue, 2-entry
// result buffer and power sequencing. Define ALU_ISSUER_AUTO_OFF_EN for idle power-down.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int N           = ALU_N,
    parameter int DEPTH       = 4,
    parameter int IDLE_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    alu_cmd_issuer_if.slave bus,
    output logic          alu_rst,
    output logic          alu_on,
    output logic          alu_off,
    output logic [3:0]    alu_op,
    output logic [N-1:0]  alu_in,
    input  logic [N-1:0]  alu_out,
    output logic          alu_powered
);

    localparam int FW = N + 5;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [FW-1:0] fifo_head_s;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_empty_s, push_s, pop_s;
    logic [3:0]    head_op_s;
    logic          head_last_s;
    logic [N-1:0]  head_data_s;

    state_e        state_q, state_d;
    logic          alu_rst_q, alu_rst_d, alu_on_q, alu_on_d, alu_off_q, alu_off_d;
    logic [3:0]    alu_op_q, alu_op_d;
    logic [N-1:0]  alu_in_q, alu_in_d;
    logic          powered_q, powered_d, ready_en_q, ready_en_d;
    logic          in_flight_q, in_flight_d, tag_err_q, tag_err_d;
    logic [3:0]    tag_op_q, tag_op_d;

    res_rec_t      res_mem_q [2];
    res_rec_t      res_mem_d [2];
    res_rec_t      res_head_s;
    logic          res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [1:0]    res_cnt_q, res_cnt_d, res_free_s;
    logic          deq_s, pop_ok_s, idle_hit_s;

    alu_cmd_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data ({bus.cmd_op, bus.cmd_last, bus.cmd_data}),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .count     (fifo_count_s)
    );

    assign {head_op_s, head_last_s, head_data_s} = fifo_head_s;
    assign fifo_empty_s  = (fifo_count_s == CW'(0));
    assign bus.cmd_ready = ready_en_q && (fifo_count_s != CW'(DEPTH));
    assign push_s        = bus.cmd_valid && bus.cmd_ready;

    // A result leaving this cycle frees its slot for a pop issued now.
    assign deq_s      = (res_cnt_q != 2'd0) && bus.res_ready;
    assign res_free_s = 2'd2 - res_cnt_q + {1'b0, deq_s};
    assign pop_ok_s   = !fifo_empty_s && (res_free_s > {1'b0, in_flight_q});

`ifdef ALU_ISSUER_AUTO_OFF_EN
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          idle_s;

    assign idle_s = (state_q == ST_RUN) && fifo_empty_s && !in_flight_q;

    // Consecutive idle-cycle counter; expiry requests power-down
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        idle_hit_s = 1'b0;
        if (push_s || !idle_s) begin
            idle_cnt_d = IW'(0);
        end else if (idle_cnt_q == IW'(IDLE_CYCLES - 1)) begin
            idle_hit_s = 1'b1;
            idle_cnt_d = IW'(0);
        end else begin
            idle_cnt_d = idle_cnt_q + IW'(1);
        end
    end

    // Idle counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= IW'(0);
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic unused_idle_cycles_s;
    assign unused_idle_cycles_s = (IDLE_CYCLES != 0);
    assign idle_hit_s           = 1'b0;
`endif

    // Power FSM, issue decision and registered ALU pin values
    always_comb begin
        state_d     = state_q;
        alu_rst_d   = 1'b0;
        alu_on_d    = 1'b0;
        alu_off_d   = 1'b0;
        alu_op_d    = OP_NOP;
        alu_in_d    = alu_in_q;
        powered_d   = powered_q;
        ready_en_d  = 1'b1;
        pop_s       = 1'b0;
        in_flight_d = 1'b0;
        tag_op_d    = tag_op_q;
        tag_err_d   = tag_err_q;
        case (state_q)
            ST_RUN: begin
                if (pop_ok_s) begin
                    pop_s       = 1'b1;
                    in_flight_d = 1'b1;
                    tag_op_d    = head_op_s;
                    tag_err_d   = !op_is_legal(head_op_s);
                    alu_op_d    = op_is_legal(head_op_s) ? head_op_s : OP_NOP;
                    alu_in_d    = head_data_s;
                    state_d     = head_last_s ? ST_SLEEP : ST_RUN;
                end else begin
                    state_d = idle_hit_s ? ST_SLEEP : ST_RUN;
                end
            end
            ST_SLEEP: begin
                alu_off_d = 1'b1;
                powered_d = 1'b0;
                state_d   = ST_OFF;
            end
            ST_OFF: begin
                if (!fifo_empty_s) begin
                    state_d = ST_WAKE;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_WAKE: begin
                alu_on_d  = 1'b1;
                powered_d = 1'b1;
                state_d   = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Result buffer: capture the ALU output the cycle after an issue
    always_comb begin
        res_mem_d = res_mem_q;
        if (in_flight_q) begin
            res_mem_d[res_wr_q] = '{op: tag_op_q, err: tag_err_q, data: ALU_N'(alu_out)};
        end else begin
            res_mem_d = res_mem_q;
        end
        res_wr_d  = res_wr_q ^ in_flight_q;
        res_rd_d  = res_rd_q ^ deq_s;
        res_cnt_d = res_cnt_q + {1'b0, in_flight_q} - {1'b0, deq_s};
    end

    // State, pin and result-buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            alu_rst_q   <= 1'b1;
            alu_on_q    <= 1'b0;
            alu_off_q   <= 1'b0;
            alu_op_q    <= OP_NOP;
            alu_in_q    <= N'(0);
            powered_q   <= 1'b1;
            ready_en_q  <= 1'b0;
            in_flight_q <= 1'b0;
            tag_op_q    <= 4'd0;
            tag_err_q   <= 1'b0;
            res_mem_q   <= '{default: '0};
            res_wr_q    <= 1'b0;
            res_rd_q    <= 1'b0;
            res_cnt_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            alu_rst_q   <= alu_rst_d;
            alu_on_q    <= alu_on_d;
            alu_off_q   <= alu_off_d;
            alu_op_q    <= alu_op_d;
            alu_in_q    <= alu_in_d;
            powered_q   <= powered_d;
            ready_en_q  <= ready_en_d;
            in_flight_q <= in_flight_d;
            tag_op_q    <= tag_op_d;
            tag_err_q   <= tag_err_d;
            res_mem_q   <= res_mem_d;
            res_wr_q    <= res_wr_d;
            res_rd_q    <= res_rd_d;
            res_cnt_q   <= res_cnt_d;
        end
    end

    assign alu_rst       = alu_rst_q;
    assign alu_on        = alu_on_q;
    assign alu_off       = alu_off_q;
    assign alu_op        = alu_op_q;
    assign alu_in        = alu_in_q;
    assign alu_powered   = powered_q;
    assign res_head_s    = res_mem_q[res_rd_q];
    assign bus.res_valid = (res_cnt_q != 2'd0);
    assign bus.res_data  = N'(res_head_s.data);
    assign bus.res_op    = res_head_s.op;
    assign bus.res_err   = res_head_s.err;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural accumulator ALU attached.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alu_rst, alu_on, alu_off, alu_powered;
    logic [3:0] alu_op;
    logic [7:0] alu_in, alu_out;
    logic [7:0] acc = 8'd0;
    int         cyc = 0;
    int         off_cnt = 0;
    int         on_cnt = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         last_acc_cyc = 0;

    typedef struct {
        logic [7:0] data;
        logic [3:0] op;
        logic       err;
        int         cyc;
    } res_t;
    res_t res_q[$];

    logic [7:0] exp1 [4] = '{8'h10, 8'h16, 8'h12, 8'h24};
    logic [3:0] ops2 [5] = '{OP_LOAD, OP_NOT, OP_XOR, OP_AND, OP_OR};
    logic [7:0] din2 [5] = '{8'hFF, 8'h00, 8'h49, 8'h06, 8'h0A};
    logic [7:0] exp2 [5] = '{8'hFF, 8'h00, 8'h49, 8'h00, 8'h0A};

    always #5 clk = ~clk;

    alu_cmd_issuer_if #(.N(8)) bus ();

    alu_cmd_issuer #(.N(8), .DEPTH(4), .IDLE_CYCLES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .alu_rst     (alu_rst),
        .alu_on      (alu_on),
        .alu_off     (alu_off),
        .alu_op      (alu_op),
        .alu_in      (alu_in),
        .alu_out     (alu_out),
        .alu_powered (alu_powered)
    );

    // Accumulator ALU: combinational result, accumulator updated every clock
    always_comb begin
        alu_out = acc;
        case (alu_op)
            OP_LOAD: alu_out = alu_in;
            OP_NOT:  alu_out = ~acc;
            OP_XOR:  alu_out = acc ^ alu_in;
            OP_OR:   alu_out = acc | alu_in;
            OP_AND:  alu_out = acc & alu_in;
            OP_SUB:  alu_out = acc - alu_in;
            OP_ADD:  alu_out = acc + alu_in;
            OP_MULT: alu_out = acc * alu_in;
            default: alu_out = acc;
        endcase
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (alu_rst || alu_off || alu_on) acc <= 8'd0;
        else                              acc <= alu_out;
    end

    // Result and power-pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready)
            res_q.push_back('{data: bus.res_data, op: bus.res_op, err: bus.res_err, cyc: cyc});
        if (!rst && alu_off) off_cnt <= off_cnt + 1;
        if (!rst && alu_on)  on_cnt  <= on_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [7:0] d, input logic last);
        bit ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        bus.cmd_last  = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                last_acc_cyc = cyc;
                break;
            end
        end
        step(1);
        bus.cmd_valid = 1'b0;
        if (!ok) check_val("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_count(input int target);
        for (int i = 0; i < 500; i++) begin
            if (res_q.size() >= target) break;
            step(1);
        end
        if (res_q.size() < target) check_val("result_timeout", res_q.size(), target);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b, first, o, n_on;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'd0;
        bus.cmd_data  = 8'd0;
        bus.cmd_last  = 1'b0;
        bus.res_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_alu_rst", alu_rst, 1);
        check_val("rst_alu_on", alu_on, 0);
        check_val("rst_alu_off", alu_off, 0);
        check_val("rst_alu_op", alu_op, OP_NOP);
        check_val("rst_alu_in", alu_in, 0);
        check_val("rst_res_valid", bus.res_valid, 0);
        check_val("rst_res_data", bus.res_data, 0);
        check_val("rst_res_err", bus.res_err, 0);
        check_val("rst_cmd_ready", bus.cmd_ready, 0);
        check_val("rst_powered", alu_powered, 1);
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check_val("rel_alu_rst_hi", alu_rst, 1);
        @(negedge clk);
        check_val("rel_alu_rst_lo", alu_rst, 0);
        check_val("rel_cmd_ready", bus.cmd_ready, 1);
        step(1);

        // Arithmetic sequence and first-result latency
        b = res_q.size();
        send(OP_LOAD, 8'h10, 1'b0);
        first = last_acc_cyc;
        send(OP_ADD, 8'h06, 1'b0);
        send(OP_SUB, 8'h04, 1'b0);
        send(OP_MULT, 8'h02, 1'b0);
        wait_count(b + 4);
        for (int i = 0; i < 4; i++)
            check_val($sformatf("t1_res%0d", i), res_q[b + i].data, exp1[i]);
        check_val("t1_latency", res_q[b].cyc - first, 3);
        check_val("t1_op0", res_q[b].op, OP_LOAD);

        // Logic ops back-to-back, one result per cycle
        b = res_q.size();
        for (int i = 0; i < 5; i++) send(ops2[i], din2[i], 1'b0);
        wait_count(b + 5);
        for (int i = 0; i < 5; i++)
            check_val($sformatf("t2_res%0d", i), res_q[b + i].data, exp2[i]);
        for (int i = 1; i < 5; i++)
            check_val($sformatf("t2_gap%0d", i), res_q[b + i].cyc - res_q[b + i - 1].cyc, 1);

        // Power down on last, wake on demand
        b = res_q.size();
        o = off_cnt;
        n_on = on_cnt;
        send(OP_ADD, 8'h05, 1'b1);
        wait_count(b + 1);
        step(4);
        check_val("t3_last_res", res_q[b].data, 8'h0F);
        check_val("t3_off_pulses", off_cnt - o, 1);
        @(negedge clk);
        check_val("t3_powered_off", alu_powered, 0);
        step(1);
        send(OP_ADD, 8'h29, 1'b0);
        wait_count(b + 2);
        check_val("t3_wake_res", res_q[b + 1].data, 8'h29);
        check_val("t3_on_pulses", on_cnt - n_on, 1);
        @(negedge clk);
        check_val("t3_powered_on", alu_powered, 1);
        step(1);

        // Backpressure: buffer full, FIFO fills, no loss on drain
        bus.res_ready = 1'b0;
        b = res_q.size();
        send(OP_LOAD, 8'h01, 1'b0);
        for (int i = 1; i < 6; i++) send(OP_ADD, 8'h01, 1'b0);
        step(2);
        @(negedge clk);
        check_val("t4_cmd_ready_full", bus.cmd_ready, 0);
        check_val("t4_res_valid", bus.res_valid, 1);
        check_val("t4_head", bus.res_data, 8'h01);
        check_val("t4_none_taken", res_q.size(), b);
        step(3);
        @(negedge clk);
        check_val("t4_head_stable", bus.res_data, 8'h01);
        step(1);
        bus.res_ready = 1'b1;
        wait_count(b + 6);
        for (int i = 0; i < 6; i++)
            check_val($sformatf("t4_res%0d", i), res_q[b + i].data, i + 1);

        // Illegal opcode issues as NOP and flags the result
        b = res_q.size();
        send(OP_LOAD, 8'h33, 1'b0);
        send(4'hC, 8'h55, 1'b0);
        wait_count(b + 2);
        check_val("t5_load", res_q[b].data, 8'h33);
        check_val("t5_load_err", res_q[b].err, 0);
        check_val("t5_ill_data", res_q[b + 1].data, 8'h33);
        check_val("t5_ill_err", res_q[b + 1].err, 1);

        // Reset with commands queued flushes everything
        bus.res_ready = 1'b0;
        send(OP_LOAD, 8'h11, 1'b0);
        send(OP_ADD, 8'h01, 1'b0);
        send(OP_ADD, 8'h01, 1'b0);
        step(1);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        o = off_cnt;
        @(negedge clk);
        check_val("t6_alu_rst_tail", alu_rst, 1);
        step(1);
        bus.res_ready = 1'b1;
        b = res_q.size();
        step(10);
        check_val("t6_no_results", res_q.size(), b);
        @(negedge clk);
        check_val("t6_res_valid", bus.res_valid, 0);
        step(1);

        // Idle behaviour
`ifdef ALU_ISSUER_AUTO_OFF_EN
        step(20);
        check_val("t7_auto_off", off_cnt - o, 1);
`else
        step(100);
        check_val("t7_no_auto_off", off_cnt - o, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Host-side command front end for the accumulator ALU: it accepts opcode/operand commands over a valid/ready handshake, buffers them in a small FIFO and drives the ALU's `rst/op/in/on/off` pins one command per cycle. It captures the ALU's combinational `out` for every issued command into a 2-entry result buffer with its own valid/ready handshake. It also sequences ALU power: power-up on demand, power-down on a `last` command or after idle.

## Interface
- `N`, 8: data width; must match the ALU's `n`.
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `IDLE_CYCLES`, 16: empty-FIFO cycles in RUN before auto power-down. Only used with `ALU_ISSUER_AUTO_OFF_EN`.

- `clk` in 1: single clock, shared with the ALU.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO not full.
- `cmd_op` in 4: opcode. NOP=0, LOAD=1, NOT=2, XOR=3, OR=4, AND=5, SUB=6, ADD=7, MULT=8.
- `cmd_data` in N: operand.
- `cmd_last` in 1: power the ALU down after this command.
- `alu_rst`, `alu_on`, `alu_off` out 1: registered drives to the ALU.
- `alu_op` out 4: registered opcode drive to the ALU.
- `alu_in` out N: registered operand drive to the ALU.
- `alu_out` in N: ALU combinational result.
- `res_valid` out 1: result buffer not empty.
- `res_ready` in 1: host accepts the result.
- `res_data` out N: captured `alu_out`.
- `res_op` out 4: opcode that produced the result.
- `res_err` out 1: the command's opcode was >8.
- `alu_powered` out 1: the issuer's view of ALU power.

## Operation
- FSM states: RUN, SLEEP, OFF, WAKE. Reset state is RUN, because `alu_rst` powers the ALU on and clears its accumulator.
- Reset values:
  - `alu_rst`=1; `alu_on`, `alu_off`=0; `alu_op`=NOP; `alu_in`=0.
  - `res_valid`=0, `res_data`=0, `res_op`=0, `res_err`=0.
  - `cmd_ready`=0 during reset, 1 after.
  - `alu_powered`=1.
  - FIFO and result buffer are empty; in-flight flag=0.
- RUN: pop the FIFO head when the FIFO is not empty and free result slots > in-flight count.
  - A pop registers `alu_op`/`alu_in` and sets the in-flight tag.
  - A non-popping cycle drives NOP, which holds the accumulator.
  - A popped command with `cmd_last`=1 moves the FSM to SLEEP.
- SLEEP: drive `alu_off`=1 and NOP for one cycle, then go to OFF with `alu_powered`=0. The ALU clears its accumulator to 0.
- OFF: drive NOP. When the FIFO is not empty, go to WAKE.
- WAKE: drive `alu_on`=1 and NOP for one cycle, then go to RUN. No pop occurs in WAKE. The accumulator starts at 0.
- Illegal opcode (>8): issue as NOP and set `res_err`=1 on its result, with `res_data` equal to the held accumulator.
- Result capture: in the cycle after an issue, sample `alu_out` into the result buffer tail, tagged with op and err.
- Result order matches command order.
- Push and pop in the same cycle are allowed. `cmd_ready` depends only on the FIFO occupancy count.
- Reset mid-operation flushes the FIFO, the in-flight tag and the result buffer.

## Timing
- Command accepted (cycle t) → earliest pop at t+1 → ALU pins change at t+2 → capture at end of t+2 → `res_valid` at t+3.
- Latency from pop to `res_valid` is 2 cycles.
- Throughput is 1 command/cycle while `res_ready`=1. When the result buffer is full and one op is in flight, pops stall.
- Power-up cost: 1 WAKE cycle. The SLEEP off pulse immediately follows the last op's ALU cycle.
- `res_data` is stable while `res_valid && !res_ready`.
- After `rst` falls, `alu_rst` stays high for exactly one more cycle, then the FSM drives normal values.

## Configuration
- `ALU_ISSUER_AUTO_OFF_EN` defined: in RUN, an idle counter counts consecutive cycles with the FIFO empty and nothing in flight.
  - Reaching `IDLE_CYCLES` moves the FSM to SLEEP.
  - Any push clears the counter.
- Not defined: there is no counter, and the FSM leaves RUN only via `cmd_last`.

## Structure
- The shared package `alu_pkg` holds:
  - the opcode localparams (NOP…MULT);
  - the FSM state enum;
  - the result record type {op, err, data}.
- One sub-module, `alu_cmd_fifo`: a parameterised sync FIFO with count output. It is instantiated for commands. The 2-entry result buffer is written inline.

## Test plan
- Reset, then push LOAD 0x10, ADD 0x06, SUB 0x04, MULT 0x02 with `res_ready`=1 → results 0x10, 0x16, 0x12, 0x24 in order, first `res_valid` 3 cycles after the first accept.
- Push LOAD 0xFF, NOT 0x00, XOR 0x49, AND 0x06, OR 0x0A back-to-back → 0xFF, 0x00, 0x49, 0x00, 0x0A, issued one per cycle.
- Push ADD 0x05 with `cmd_last`=1 → one `alu_off` pulse and `alu_powered`=0. A later ADD 0x29 → one WAKE `alu_on` pulse, result 0x29 (accumulator was cleared).
- Hold `res_ready`=0 and push 6 commands (DEPTH=4) → `cmd_ready` drops when the FIFO is full. Exactly 2 results are buffered with no loss; releasing `res_ready` drains all 6 in order.
- Push op 0xC after LOAD 0x33 → result 0x33 with `res_err`=1.
- Assert `rst` with 3 commands queued → no further results; `alu_rst` high through the cycle after release.
- With `ALU_ISSUER_AUTO_OFF_EN`: idle 16 cycles → SLEEP pulse. Without it: no `alu_off` after 100 idle cycles.
